fpaddsub_normalize_round: RTL and testbench

Sequential post-processing stage for the half-precision FP add/sub datapath. Consumes the raw 17-bit mantissa sum, result sign and effective operation produced by the add/sub execution stage, together with the larger operand's exponent. Normalizes the sum with an iterative one-bit-per-cycle left shifter, rounds to nearest-even, and emits a packed 16-bit result through a valid/ready handshake. It sits between the execution stage and the attention-layer accumulators.

---
 rtl/fpaddsub_pkg.sv | 19 +
 rtl/fpaddsub_round_rne.sv | 40 ++++
 rtl/fpaddsub_normalize_round.sv | 185 ++++++++++++++++++
 tb/tb_fpaddsub_normalize_round.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpaddsub_pkg.sv
// Shared constants and state encoding for the half-precision add/sub
// normalize-and-round stage.
package fpaddsub_pkg;

    localparam int EXPONENT = 5;
    localparam int MANTISSA = 10;
    localparam int DWIDTH   = 1 + EXPONENT + MANTISSA;
    localparam int EXP_BIAS = 15;
    localparam int EXP_INF  = 31;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        SHIFT,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/fpaddsub_round_rne.sv
// Round-to-nearest-even for a normalized (or subnormal) mantissa.
// Saturates to the infinity encoding when the exponent reaches all-ones.
module fpaddsub_round_rne #(
    parameter int EXPONENT = 5,
    parameter int MANTISSA = 10
) (
    input  logic [MANTISSA-1:0] mant,
    input  logic                guard,
    input  logic                sticky,
    input  logic [EXPONENT:0]   exp,
    output logic [MANTISSA-1:0] mant_out,
    output logic [EXPONENT-1:0] exp_out,
    output logic                ovf,
    output logic                inexact
);

    localparam int EXP_MAX = (1 << EXPONENT) - 1;

    logic                round_up;
    logic                carry;
    logic [MANTISSA-1:0] mant_sum;
    logic [EXPONENT:0]   exp_sum;

    // Increment on guard with sticky or odd lsb; a mantissa carry bumps the exponent
    always_comb begin
        round_up          = guard & (sticky | mant[0]);
        {carry, mant_sum} = {1'b0, mant} + (MANTISSA+1)'(round_up);
        exp_sum           = exp + (EXPONENT+1)'(carry);
        inexact           = guard | sticky;
        ovf               = (exp_sum >= (EXPONENT+1)'(EXP_MAX));
        if (ovf) begin
            exp_out  = EXPONENT'(EXP_MAX);
            mant_out = '0;
        end else begin
            exp_out  = exp_sum[EXPONENT-1:0];
            mant_out = mant_sum;
        end
    end

endmodule

// File: rtl/fpaddsub_normalize_round.sv
// Normalize/round stage for the FP16 add/sub datapath. Takes the raw 17-bit
// mantissa sum, normalizes it one bit per cycle, rounds to nearest-even and
// hands out a packed result with valid/ready.
// Optional feature: define FPADD_SUBNORMAL_EN to produce subnormal results
// instead of flushing underflowing results to signed zero.
module fpaddsub_normalize_round
    import fpaddsub_pkg::*;
#(
    parameter int EXPONENT = fpaddsub_pkg::EXPONENT,
    parameter int MANTISSA = fpaddsub_pkg::MANTISSA,
    parameter int DWIDTH   = fpaddsub_pkg::DWIDTH
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DWIDTH:0]     in_sum,
    input  logic [EXPONENT-1:0] in_exp,
    input  logic                in_sgn,
    input  logic                in_opr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DWIDTH-1:0]   out_result,
    output logic                out_ovf,
    output logic                out_unf,
    output logic                out_zero,
    output logic                out_inexact
);

    localparam int HID_BIT     = DWIDTH - 1;
    localparam int GUARD_BIT   = HID_BIT - MANTISSA - 1;
    localparam int EW          = EXPONENT + 1;
    localparam int SHIFT_LIMIT = 15;

`ifdef FPADD_SUBNORMAL_EN
    localparam state_t UFLOW_NEXT = ROUND;
`else
    localparam state_t UFLOW_NEXT = DONE;
`endif

    state_t            state, next_state;
    logic [DWIDTH:0]   sum_q;
    logic [EW-1:0]     exp_q;
    logic              sgn_q, opr_q, sticky_q;
    logic [3:0]        cnt_q;

    logic [DWIDTH:0]   sum_shl;
    logic              sum_zero;
    logic              uflow;
    logic [MANTISSA-1:0] rnd_mant;
    logic [EXPONENT-1:0] rnd_exp;
    logic              rnd_ovf, rnd_inexact;
    logic [DWIDTH-1:0] rnd_result;
    logic              rnd_zero, rnd_unf;

    assign sum_shl  = {sum_q[DWIDTH-1:0], 1'b0};
    assign sum_zero = (sum_q == '0);
    // Cannot shift further left without dropping below the smallest normal exponent
    assign uflow    = (state == EVAL || state == SHIFT) && (exp_q == EW'(1)) &&
                      !sum_q[HID_BIT] && !sum_q[DWIDTH] && !sum_zero;

    fpaddsub_round_rne #(
        .EXPONENT(EXPONENT),
        .MANTISSA(MANTISSA)
    ) u_round (
        .mant    (sum_q[HID_BIT-1 -: MANTISSA]),
        .guard   (sum_q[GUARD_BIT]),
        .sticky  ((|sum_q[GUARD_BIT-1:0]) | sticky_q),
        .exp     (exp_q),
        .mant_out(rnd_mant),
        .exp_out (rnd_exp),
        .ovf     (rnd_ovf),
        .inexact (rnd_inexact)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state selection: normalization path depends on where the leading one sits
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (in_valid) next_state = EVAL;
            EVAL: begin
                if (sum_zero)                            next_state = DONE;
                else if (uflow)                          next_state = UFLOW_NEXT;
                else if (sum_q[DWIDTH] || sum_q[HID_BIT]) next_state = ROUND;
                else                                     next_state = SHIFT;
            end
            SHIFT: begin
                if (uflow)                                               next_state = UFLOW_NEXT;
                else if (sum_shl[HID_BIT] || cnt_q == 4'(SHIFT_LIMIT-1)) next_state = ROUND;
            end
            ROUND: next_state = DONE;
            DONE:  if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake and assembled rounding result; subnormal underflow when exp was forced to 0
    always_comb begin
        in_ready   = (state == IDLE);
        rnd_result = {sgn_q, rnd_exp, rnd_mant};
        rnd_zero   = (rnd_exp == '0) && (rnd_mant == '0);
        rnd_unf    = (exp_q == '0) && (rnd_inexact || ((rnd_exp == '0) && (rnd_mant != '0)));
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sum_q       <= '0;
            exp_q       <= '0;
            sgn_q       <= 1'b0;
            opr_q       <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_ovf     <= 1'b0;
            out_unf     <= 1'b0;
            out_zero    <= 1'b0;
            out_inexact <= 1'b0;
        end else if (uflow) begin
`ifdef FPADD_SUBNORMAL_EN
            exp_q       <= '0;
`else
            out_result  <= {sgn_q, {(DWIDTH-1){1'b0}}};
            out_ovf     <= 1'b0;
            out_unf     <= 1'b1;
            out_zero    <= 1'b1;
            out_inexact <= 1'b1;
            out_valid   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sum_q    <= in_sum;
                        exp_q    <= {1'b0, in_exp};
                        sgn_q    <= in_sgn;
                        opr_q    <= in_opr;
                        sticky_q <= 1'b0;
                        cnt_q    <= '0;
                    end
                end
                EVAL: begin
                    if (sum_zero) begin
                        // Cancellation under effective subtract is +0; only -0 + -0 keeps the sign
                        out_result  <= {sgn_q & ~opr_q, {(DWIDTH-1){1'b0}}};
                        out_ovf     <= 1'b0;
                        out_unf     <= 1'b0;
                        out_zero    <= 1'b1;
                        out_inexact <= 1'b0;
                        out_valid   <= 1'b1;
                    end else if (sum_q[DWIDTH]) begin
                        sum_q    <= sum_q >> 1;
                        sticky_q <= sticky_q | sum_q[0];
                        exp_q    <= exp_q + EW'(1);
                    end
                end
                SHIFT: begin
                    sum_q <= sum_shl;
                    exp_q <= exp_q - EW'(1);
                    cnt_q <= cnt_q + 4'd1;
                end
                ROUND: begin
                    out_result  <= rnd_result;
                    out_ovf     <= rnd_ovf;
                    out_unf     <= rnd_unf;
                    out_zero    <= rnd_zero;
                    out_inexact <= rnd_inexact;
                    out_valid   <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpaddsub_normalize_round.sv
// Testbench for fpaddsub_normalize_round. Expected beats are pushed to a
// scoreboard when driven and popped when the DUT presents a result.
// Underflow expectations follow FPADD_SUBNORMAL_EN.
module tb_fpaddsub_normalize_round;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:0] in_sum = '0;
    logic [4:0]  in_exp = '0;
    logic        in_sgn = 1'b0;
    logic        in_opr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic        out_ovf, out_unf, out_zero, out_inexact;

    // flags are {ovf, unf, zero, inexact}; mask selects which flags are checked
    typedef struct {
        logic [15:0] res;
        logic [3:0]  flags;
        logic [3:0]  mask;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        logic [16:0] s;
        logic [4:0]  e;
        logic        sg;
        logic        op;
        exp_t        x;
    } case_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_accept = 0;

    fpaddsub_normalize_round #(
        .EXPONENT(5),
        .MANTISSA(10),
        .DWIDTH(16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_exp     (in_exp),
        .in_sgn     (in_sgn),
        .in_opr     (in_opr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf),
        .out_zero   (out_zero),
        .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish want finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t mk(input logic [15:0] res, input logic [3:0] flags,
                                input logic [3:0] mask, input int lat);
        exp_t x;
        x.res = res; x.flags = flags; x.mask = mask; x.lat = lat;
        return x;
    endfunction

    function automatic case_t mc(input string name, input logic [16:0] s, input logic [4:0] e,
                                 input logic sg, input logic op, input exp_t x);
        case_t c;
        c.name = name; c.s = s; c.e = e; c.sg = sg; c.op = op; c.x = x;
        return c;
    endfunction

    function automatic logic [3:0] fl();
        return {out_ovf, out_unf, out_zero, out_inexact};
    endfunction

    // Drive one beat (called #1 after an edge); returns #1 after the accepting edge
    task automatic send(input logic [16:0] s, input logic [4:0] e, input logic sg,
                        input logic op, input exp_t x);
        int g = 0;
        in_sum = s; in_exp = e; in_sgn = sg; in_opr = op; in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1; g++;
        end
        sb.push_back(x);
        @(posedge clk); #1;
        last_accept = cyc;
        in_valid = 1'b0;
    endtask

    // Latency counts edges from the accepting edge through the edge that raises out_valid
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_result, fl()} !== {1'b1, 1'b0, 16'h0000, 4'h0}) begin
            n_bad++;
            $display("[TB] FAIL reset_hold: got rdy=%b vld=%b res=%h fl=%b want rdy=1 vld=0 res=0000 fl=0000",
                     in_ready, out_valid, out_result, fl());
        end
        #2 resetn = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({in_ready, out_valid, out_result} !== {1'b1, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("[TB] FAIL reset_release: got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=0000",
                     in_ready, out_valid, out_result);
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t x;
        bit   held_ok = 1'b1;
        out_ready = 1'b0;
        send(17'h10000, 5'd15, 1'b0, 1'b0, mk(16'h4000, 4'b0000, 4'b1111, 3));
        wait_valid(lat);
        x = sb.pop_front();
        n_cmp++;
        if (out_result !== x.res) begin n_bad++; $display("[TB] FAIL one_plus_one result: got %h want %h", out_result, x.res); end
        n_cmp++;
        if (lat !== x.lat) begin n_bad++; $display("[TB] FAIL one_plus_one latency: got %0d want %0d", lat, x.lat); end
        repeat (5) begin
            @(posedge clk); #1;
            if (!(out_valid === 1'b1 && out_result === x.res && in_ready === 1'b0)) held_ok = 1'b0;
        end
        n_cmp++;
        if (!held_ok) begin n_bad++; $display("[TB] FAIL backpressure_hold: got vld=%b res=%h rdy=%b want vld=1 res=%h rdy=0", out_valid, out_result, in_ready, x.res); end
        accept();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("[TB] FAIL backpressure_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready); end
    endtask

    task automatic test_cancel();
        int   lat;
        exp_t x;
        send(17'h00000, 5'd15, 1'b1, 1'b1, mk(16'h0000, 4'b0010, 4'b1111, 2));
        wait_valid(lat);
        x = sb.pop_front();
        n_cmp++;
        if (out_result !== x.res) begin n_bad++; $display("[TB] FAIL cancel result: got %h want %h", out_result, x.res); end
        n_cmp++;
        if (fl() !== x.flags) begin n_bad++; $display("[TB] FAIL cancel flags: got %b want %b", fl(), x.flags); end
        n_cmp++;
        if (lat !== x.lat) begin n_bad++; $display("[TB] FAIL cancel latency: got %0d want %0d", lat, x.lat); end
        accept();
    endtask

    task automatic test_shift_round_ovf();
        case_t tc[$];
        int    lat;
        exp_t  x;
        tc.push_back(mc("one_shift",     17'h04000, 5'd15, 1'b0, 1'b0, mk(16'h3800, 4'b0000, 4'b1111, 4)));
        tc.push_back(mc("seven_shift",   17'h00100, 5'd15, 1'b0, 1'b0, mk(16'h2000, 4'b0000, 4'b1111, 10)));
        tc.push_back(mc("tie_odd",       17'h08030, 5'd15, 1'b0, 1'b0, mk(16'h3C02, 4'b0001, 4'b1111, 3)));
        tc.push_back(mc("tie_even",      17'h08010, 5'd15, 1'b0, 1'b0, mk(16'h3C00, 4'b0001, 4'b1111, 3)));
        tc.push_back(mc("above_half",    17'h08018, 5'd15, 1'b0, 1'b0, mk(16'h3C01, 4'b0001, 4'b1111, 3)));
        tc.push_back(mc("carry_sticky",  17'h10021, 5'd15, 1'b0, 1'b0, mk(16'h4001, 4'b0001, 4'b1111, 3)));
        tc.push_back(mc("round_carry",   17'h0FFF0, 5'd15, 1'b0, 1'b0, mk(16'h4000, 4'b0001, 4'b1111, 3)));
        tc.push_back(mc("negative",      17'h0C000, 5'd15, 1'b1, 1'b0, mk(16'hBE00, 4'b0000, 4'b1111, 3)));
        tc.push_back(mc("ovf_round",     17'h1FFE0, 5'd30, 1'b0, 1'b0, mk(16'h7C00, 4'b1001, 4'b1111, 3)));
        tc.push_back(mc("ovf_carry",     17'h10000, 5'd30, 1'b1, 1'b0, mk(16'hFC00, 4'b1000, 4'b1111, 3)));
        tc.push_back(mc("min_normal",    17'h08000, 5'd1,  1'b0, 1'b0, mk(16'h0400, 4'b0000, 4'b1111, 3)));
        foreach (tc[i]) begin
            send(tc[i].s, tc[i].e, tc[i].sg, tc[i].op, tc[i].x);
            wait_valid(lat);
            x = sb.pop_front();
            n_cmp++;
            if (out_result !== x.res) begin n_bad++; $display("[TB] FAIL %s result: got %h want %h", tc[i].name, out_result, x.res); end
            n_cmp++;
            if ((fl() & x.mask) !== (x.flags & x.mask)) begin n_bad++; $display("[TB] FAIL %s flags: got %b want %b", tc[i].name, fl(), x.flags); end
            n_cmp++;
            if (lat !== x.lat) begin n_bad++; $display("[TB] FAIL %s latency: got %0d want %0d", tc[i].name, lat, x.lat); end
            accept();
        end
    endtask

    task automatic test_underflow();
        case_t tc[$];
        int    lat;
        exp_t  x;
`ifdef FPADD_SUBNORMAL_EN
        tc.push_back(mc("uflow_eval",   17'h04000, 5'd1, 1'b0, 1'b0, mk(16'h0200, 4'b0100, 4'b1111, 3)));
        tc.push_back(mc("uflow_shift",  17'h02000, 5'd2, 1'b0, 1'b0, mk(16'h0200, 4'b0100, 4'b1111, 5)));
        tc.push_back(mc("uflow_promote",17'h07FF0, 5'd1, 1'b0, 1'b0, mk(16'h0400, 4'b0101, 4'b1111, 3)));
        tc.push_back(mc("uflow_neg",    17'h04000, 5'd1, 1'b1, 1'b0, mk(16'h8200, 4'b0100, 4'b1111, 3)));
`else
        tc.push_back(mc("uflow_eval",   17'h04000, 5'd1, 1'b0, 1'b0, mk(16'h0000, 4'b0110, 4'b1110, 2)));
        tc.push_back(mc("uflow_shift",  17'h02000, 5'd2, 1'b0, 1'b0, mk(16'h0000, 4'b0110, 4'b1110, 4)));
        tc.push_back(mc("uflow_promote",17'h07FF0, 5'd1, 1'b0, 1'b0, mk(16'h0000, 4'b0110, 4'b1110, 2)));
        tc.push_back(mc("uflow_neg",    17'h04000, 5'd1, 1'b1, 1'b0, mk(16'h8000, 4'b0110, 4'b1110, 2)));
`endif
        foreach (tc[i]) begin
            send(tc[i].s, tc[i].e, tc[i].sg, tc[i].op, tc[i].x);
            wait_valid(lat);
            x = sb.pop_front();
            n_cmp++;
            if (out_result !== x.res) begin n_bad++; $display("[TB] FAIL %s result: got %h want %h", tc[i].name, out_result, x.res); end
            n_cmp++;
            if ((fl() & x.mask) !== (x.flags & x.mask)) begin n_bad++; $display("[TB] FAIL %s flags: got %b want %b", tc[i].name, fl(), x.flags); end
            n_cmp++;
            if (lat !== x.lat) begin n_bad++; $display("[TB] FAIL %s latency: got %0d want %0d", tc[i].name, lat, x.lat); end
            accept();
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen = 1'b0;
        send(17'h00100, 5'd15, 1'b0, 1'b0, mk(16'h2000, 4'b0000, 4'b1111, 10));
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2 resetn = 1'b0;
        #2;
        n_cmp++;
        if ({in_ready, out_valid, out_result} !== {1'b1, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("[TB] FAIL midop_reset: got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=0000", in_ready, out_valid, out_result);
        end
        #1 resetn = 1'b1;
        // the aborted beat never comes out, so its expectation is discarded
        sb.delete();
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("[TB] FAIL midop_no_beat: got out_valid=1 want out_valid=0"); end
    endtask

    task automatic test_back_to_back();
        case_t tc[$];
        int    lat;
        int    prev_accept;
        int    prev_lat;
        exp_t  x;
        tc.push_back(mc("b2b_tie_odd", 17'h08030, 5'd15, 1'b0, 1'b0, mk(16'h3C02, 4'b0001, 4'b1111, 3)));
        tc.push_back(mc("b2b_shift",   17'h04000, 5'd15, 1'b0, 1'b0, mk(16'h3800, 4'b0000, 4'b1111, 4)));
        tc.push_back(mc("b2b_cancel",  17'h00000, 5'd20, 1'b1, 1'b1, mk(16'h0000, 4'b0010, 4'b1111, 2)));
        tc.push_back(mc("b2b_ovf",     17'h1FFE0, 5'd30, 1'b0, 1'b0, mk(16'h7C00, 4'b1001, 4'b1111, 3)));
        prev_accept = -1;
        prev_lat    = 0;
        out_ready   = 1'b1;
        foreach (tc[i]) begin
            send(tc[i].s, tc[i].e, tc[i].sg, tc[i].op, tc[i].x);
            if (prev_accept >= 0) begin
                n_cmp++;
                if (last_accept - prev_accept !== prev_lat + 1) begin
                    n_bad++;
                    $display("[TB] FAIL %s period: got %0d want %0d", tc[i].name, last_accept - prev_accept, prev_lat + 1);
                end
            end
            prev_accept = last_accept;
            wait_valid(lat);
            x = sb.pop_front();
            prev_lat = x.lat;
            n_cmp++;
            if (out_result !== x.res) begin n_bad++; $display("[TB] FAIL %s result: got %h want %h", tc[i].name, out_result, x.res); end
            n_cmp++;
            if (fl() !== x.flags) begin n_bad++; $display("[TB] FAIL %s flags: got %b want %b", tc[i].name, fl(), x.flags); end
            n_cmp++;
            if (lat !== x.lat) begin n_bad++; $display("[TB] FAIL %s latency: got %0d want %0d", tc[i].name, lat, x.lat); end
            accept();
        end
    endtask

    initial begin
        $display("[TB] starting fpaddsub_normalize_round bench");
        test_reset();
        test_backpressure();
        test_cancel();
        test_shift_round_ovf();
        test_underflow();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
